// File: rtl/timer_counter.sv
// ---------------------------------------------------------------------------
// timer_counter
//   Memory-mapped programmable 32-bit down-counter timer. One instance serves
//   one timer window behind the system bridge. Software programs PRESET and
//   CTRL; the timer loads PRESET into COUNT, counts down to zero and raises an
//   interrupt flag. One-shot modes stop by clearing CTRL.Enable; auto-reload
//   (Mode 1) reloads PRESET and pulses the flag for one cycle per period.
//
//   Register map (Addr[3:2]):
//     0 CTRL   rw  [0] Enable, [2:1] Mode, [3] IM (interrupt mask), rest 0
//     1 PRESET rw  reload value
//     2 COUNT  ro  current count
//     3 -      reads 0, writes ignored
//
// Ports
//   clk    in   1   system clock, rising-edge active
//   reset  in   1   synchronous active-low reset
//   Addr   in   30  word address [31:2]; only [3:2] decoded
//   WE     in   1   write enable (already range-qualified by the bridge)
//   Din    in   32  write data
//   Dout   out  32  read data, combinational on Addr[3:2]
//   IRQ    out  1   interrupt request = CTRL.IM & irq flag
// ---------------------------------------------------------------------------
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_RELOAD = 2'd1;

  state_t      state_r;
  state_t      state_nx_s;
  logic [3:0]  ctrl_r;
  logic [3:0]  ctrl_nx_s;
  logic [31:0] preset_r;
  logic [31:0] preset_nx_s;
  logic [31:0] count_r;
  logic [31:0] count_nx_s;
  logic        irq_flag_r;
  logic        irq_flag_nx_s;

  logic        ctrl_en_s;
  logic [1:0]  ctrl_mode_s;
  logic        ctrl_im_s;
  logic        wr_ctrl_s;
  logic        wr_preset_s;
  logic        flag_set_s;
  logic        flag_clr_hw_s;
  logic        en_clr_hw_s;

  // Upper address bits are outside the decoded window; kept only for lint.
  logic        unused_addr_s;
  assign unused_addr_s = ^Addr[31:4];

  assign ctrl_en_s   = ctrl_r[0];
  assign ctrl_mode_s = ctrl_r[2:1];
  assign ctrl_im_s   = ctrl_r[3];

  assign wr_ctrl_s   = WE & (Addr[3:2] == 2'd0);
  assign wr_preset_s = WE & (Addr[3:2] == 2'd1);

  // Next-state and hardware-side register effects of the counting FSM.
  always_comb begin
    state_nx_s    = state_r;
    count_nx_s    = count_r;
    flag_set_s    = 1'b0;
    flag_clr_hw_s = 1'b0;
    en_clr_hw_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ctrl_en_s) begin
          state_nx_s = ST_LOAD;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // A zero preset has nothing to count: terminate straight away so an
        // auto-reload period with PRESET=0 is two cycles.
        if (preset_r == 32'd0) begin
          count_nx_s = 32'd0;
          flag_set_s = 1'b1;
          state_nx_s = ST_INT;
        end else begin
          count_nx_s = preset_r;
          state_nx_s = ST_CNT;
        end
      end
      ST_CNT: begin
        if (!ctrl_en_s) begin
          state_nx_s = ST_IDLE;
        end else if (count_r <= 32'd1) begin
          // Zero is terminal; never decrement past it.
          count_nx_s = 32'd0;
          flag_set_s = 1'b1;
          state_nx_s = ST_INT;
        end else begin
          count_nx_s = count_r - 32'd1;
        end
      end
      ST_INT: begin
        if (ctrl_mode_s == MODE_RELOAD) begin
          flag_clr_hw_s = 1'b1;
          state_nx_s    = ST_LOAD;
        end else begin
          en_clr_hw_s = 1'b1;
          state_nx_s  = ST_IDLE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Merge software writes with hardware updates; software has priority.
  always_comb begin
    ctrl_nx_s     = ctrl_r;
    preset_nx_s   = preset_r;
    irq_flag_nx_s = irq_flag_r;
    if (wr_ctrl_s) begin
      ctrl_nx_s = Din[3:0];
    end else if (en_clr_hw_s) begin
      ctrl_nx_s = {ctrl_r[3:1], 1'b0};
    end else begin
      ctrl_nx_s = ctrl_r;
    end
    if (wr_preset_s) begin
      preset_nx_s = Din;
    end else begin
      preset_nx_s = preset_r;
    end
    // Any CTRL/PRESET write acknowledges the interrupt, even against a set.
    if (wr_ctrl_s || wr_preset_s) begin
      irq_flag_nx_s = 1'b0;
    end else if (flag_set_s) begin
      irq_flag_nx_s = 1'b1;
    end else if (flag_clr_hw_s) begin
      irq_flag_nx_s = 1'b0;
    end else begin
      irq_flag_nx_s = irq_flag_r;
    end
  end

  // State and register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      ctrl_r     <= 4'd0;
      preset_r   <= 32'd0;
      count_r    <= 32'd0;
      irq_flag_r <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      ctrl_r     <= ctrl_nx_s;
      preset_r   <= preset_nx_s;
      count_r    <= count_nx_s;
      irq_flag_r <= irq_flag_nx_s;
    end
  end

  // Read mux; reserved offset reads zero.
  always_comb begin
    Dout = 32'd0;
    case (Addr[3:2])
      2'd0:    Dout = {28'd0, ctrl_r};
      2'd1:    Dout = preset_r;
      2'd2:    Dout = count_r;
      default: Dout = 32'd0;
    endcase
  end

  assign IRQ = ctrl_im_s & irq_flag_r;

endmodule

// File: tb/tb_timer_counter.sv
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [31:2] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int total;
  int bad;

  typedef struct packed {
    logic [31:0] cnt;
    logic        irq;
  } exp_t;

  exp_t sb_q[$];

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (addr),
    .WE    (we),
    .Din   (din),
    .Dout  (dout),
    .IRQ   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = {28'd0, a};
    din  = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we   = 1'b0;
  endtask

  task automatic push(input logic [31:0] c, input logic i);
    exp_t e;
    e.cnt = c;
    e.irq = i;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b0;
    repeat (2) tick();
    for (int a = 0; a < 3; a++) begin
      addr = 30'(a);
      #1;
      total++;
      if (dout !== 32'd0) begin
        bad++;
        $display("FAIL reset_reg%0d: got %h want %h", a, dout, 32'd0);
      end
    end
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_irq: got %b want 0", irq);
    end
    reset = 1'b1;
    tick();
    wr(2'd3, 32'hFFFF_FFFF);
    addr = 30'd3;
    #1;
    total++;
    if (dout !== 32'd0) begin
      bad++;
      $display("FAIL reserved_read: got %h want %h", dout, 32'd0);
    end
    for (int a = 0; a < 3; a++) begin
      addr = 30'(a);
      #1;
      total++;
      if (dout !== 32'd0) begin
        bad++;
        $display("FAIL reserved_side_effect%0d: got %h want %h", a, dout, 32'd0);
      end
    end
    e = '0;
  endtask

  task automatic test_oneshot();
    exp_t e;
    int   ec[8] = '{0, 5, 4, 3, 2, 1, 0, 0};
    bit   ei[8] = '{0, 0, 0, 0, 0, 0, 1, 1};
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (int i = 0; i < 8; i++) push(32'(ec[i]), ei[i]);
    while (sb_q.size() != 0) begin
      tick();
      addr = 30'd2;
      #1;
      e = sb_q.pop_front();
      total++;
      if (dout !== e.cnt || irq !== e.irq) begin
        bad++;
        $display("FAIL oneshot_seq: got count=%0d irq=%b want count=%0d irq=%b",
                 dout, irq, e.cnt, e.irq);
      end
    end
    addr = 30'd0;
    #1;
    total++;
    if (dout !== 32'h8 || irq !== 1'b1) begin
      bad++;
      $display("FAIL oneshot_done: got ctrl=%h irq=%b want ctrl=%h irq=1", dout, irq, 32'h8);
    end
    wr(2'd0, 32'h8);
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL oneshot_ack: got irq=%b want 0", irq);
    end
    tick();
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL oneshot_ack_hold: got irq=%b want 0", irq);
    end
  endtask

  task automatic test_autoreload();
    exp_t e;
    int   ec[12] = '{0, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0, 3};
    bit   ei[12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int i = 0; i < 12; i++) push(32'(ec[i]), ei[i]);
    while (sb_q.size() != 0) begin
      tick();
      addr = 30'd2;
      #1;
      e = sb_q.pop_front();
      total++;
      if (dout !== e.cnt || irq !== e.irq) begin
        bad++;
        $display("FAIL reload_seq: got count=%0d irq=%b want count=%0d irq=%b",
                 dout, irq, e.cnt, e.irq);
      end
    end
    // Disable while counting at 3: this edge still decrements to 2.
    wr(2'd0, 32'h0);
  endtask

  task automatic test_pause();
    exp_t e;
    int   ec[5] = '{2, 10, 9, 8, 7};
    int   rc[3] = '{6, 10, 9};
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    for (int i = 0; i < 5; i++) push(32'(ec[i]), 1'b0);
    while (sb_q.size() != 0) begin
      tick();
      addr = 30'd2;
      #1;
      e = sb_q.pop_front();
      total++;
      if (dout !== e.cnt || irq !== e.irq) begin
        bad++;
        $display("FAIL pause_run: got count=%0d irq=%b want count=%0d irq=%b",
                 dout, irq, e.cnt, e.irq);
      end
    end
    // Enable cleared at the edge that produces 6; count must freeze there.
    wr(2'd0, 32'h0);
    for (int i = 0; i < 4; i++) push(32'd6, 1'b0);
    e = sb_q.pop_front();
    addr = 30'd2;
    #1;
    total++;
    if (dout !== e.cnt) begin
      bad++;
      $display("FAIL pause_stop: got count=%0d want count=%0d", dout, e.cnt);
    end
    while (sb_q.size() != 0) begin
      tick();
      addr = 30'd2;
      #1;
      e = sb_q.pop_front();
      total++;
      if (dout !== e.cnt || irq !== e.irq) begin
        bad++;
        $display("FAIL pause_hold: got count=%0d irq=%b want count=%0d irq=%b",
                 dout, irq, e.cnt, e.irq);
      end
    end
    wr(2'd0, 32'h1);
    for (int i = 0; i < 3; i++) push(32'(rc[i]), 1'b0);
    while (sb_q.size() != 0) begin
      tick();
      addr = 30'd2;
      #1;
      e = sb_q.pop_front();
      total++;
      if (dout !== e.cnt || irq !== e.irq) begin
        bad++;
        $display("FAIL pause_reload: got count=%0d irq=%b want count=%0d irq=%b",
                 dout, irq, e.cnt, e.irq);
      end
    end
    wr(2'd0, 32'h0);
    tick();
  endtask

  task automatic test_mask_edge();
    exp_t e;
    bit   pi[5] = '{0, 1, 0, 1, 0};
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h1);
    push(32'd8, 1'b0);
    push(32'd0, 1'b0);
    push(32'd0, 1'b0);
    while (sb_q.size() != 0) begin
      tick();
      addr = 30'd2;
      #1;
      e = sb_q.pop_front();
      total++;
      if (dout !== e.cnt || irq !== e.irq) begin
        bad++;
        $display("FAIL mask_seq: got count=%0d irq=%b want count=%0d irq=%b",
                 dout, irq, e.cnt, e.irq);
      end
    end
    addr = 30'd0;
    #1;
    total++;
    if (dout !== 32'h0) begin
      bad++;
      $display("FAIL mask_en_clear: got ctrl=%h want %h", dout, 32'h0);
    end
    wr(2'd0, 32'h8);
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL mask_ack_irq: got irq=%b want 0", irq);
    end
    // PRESET=0 in auto-reload: two-cycle period.
    wr(2'd0, 32'hB);
    for (int i = 0; i < 5; i++) push(32'd0, pi[i]);
    while (sb_q.size() != 0) begin
      tick();
      addr = 30'd2;
      #1;
      e = sb_q.pop_front();
      total++;
      if (dout !== e.cnt || irq !== e.irq) begin
        bad++;
        $display("FAIL zero_reload: got count=%0d irq=%b want count=%0d irq=%b",
                 dout, irq, e.cnt, e.irq);
      end
    end
    wr(2'd0, 32'h0);
    tick();
  endtask

  task automatic test_reset_midcount();
    exp_t e;
    wr(2'd1, 32'd20);
    wr(2'd0, 32'h9);
    push(32'd0, 1'b0);
    for (int i = 20; i >= 13; i--) push(32'(i), 1'b0);
    while (sb_q.size() != 0) begin
      tick();
      addr = 30'd2;
      #1;
      e = sb_q.pop_front();
      total++;
      if (dout !== e.cnt || irq !== e.irq) begin
        bad++;
        $display("FAIL midreset_run: got count=%0d irq=%b want count=%0d irq=%b",
                 dout, irq, e.cnt, e.irq);
      end
    end
    reset = 1'b0;
    tick();
    for (int a = 0; a < 3; a++) begin
      addr = 30'(a);
      #1;
      total++;
      if (dout !== 32'd0) begin
        bad++;
        $display("FAIL midreset_reg%0d: got %h want %h", a, dout, 32'd0);
      end
    end
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL midreset_irq: got irq=%b want 0", irq);
    end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) push(32'd0, 1'b0);
    while (sb_q.size() != 0) begin
      tick();
      addr = 30'd2;
      #1;
      e = sb_q.pop_front();
      total++;
      if (dout !== e.cnt || irq !== e.irq) begin
        bad++;
        $display("FAIL midreset_idle: got count=%0d irq=%b want count=%0d irq=%b",
                 dout, irq, e.cnt, e.irq);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    addr  = 30'd0;
    we    = 1'b0;
    din   = 32'd0;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_pause();
    test_mask_edge();
    test_reset_midcount();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
